branch_target_predictor: RTL and testbench



---
 rtl/branch_target_predictor.sv | 182 ++++++++++++++++++
 tb/tb_branch_target_predictor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Fetch-side branch target predictor with ID-stage misprediction resolution.
// A direct-mapped BTB with per-entry saturating counters predicts the next
// fetch PC; the resolver compares resolved control flow with the fetched PC,
// emits a flush code plus redirect PC, then trains the table and perf counters.
module branch_target_predictor #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 4,
    parameter int CNT_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    input  logic                 id_valid,
    input  logic                 stall,
    input  logic [WORD_SIZE-1:0] id_pc,
    input  logic [WORD_SIZE-1:0] id_pc_1,
    input  logic                 is_jtype,
    input  logic                 is_branch,
    input  logic                 is_jr,
    input  logic                 br_cond,
    input  logic [WORD_SIZE-1:0] jmp_target,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic [WORD_SIZE-1:0] jr_target,
    output logic [2:0]           flush_code,
    output logic [WORD_SIZE-1:0] correct_pc,
    output logic [WORD_SIZE-1:0] ctrl_count,
    output logic [WORD_SIZE-1:0] mispred_count
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = WORD_SIZE - IDX_BITS;

    localparam logic [WORD_SIZE-1:0] ONE_W    = WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] WORD_MAX = '1;
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0]  CNT_WEAK = CNT_ONE << (CNT_BITS - 1);

    localparam logic [2:0] FL_NICE   = 3'd0;
    localparam logic [2:0] FL_JUMP   = 3'd1;
    localparam logic [2:0] FL_BR_TK  = 3'd2;
    localparam logic [2:0] FL_BR_NT  = 3'd3;
    localparam logic [2:0] FL_JR     = 3'd4;
    localparam logic [2:0] FL_FALSE  = 3'd5;

    // Saturating counter helpers
    function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    function automatic logic [CNT_BITS-1:0] cnt_dec(input logic [CNT_BITS-1:0] c);
        return (c == '0) ? c : c - CNT_ONE;
    endfunction

    function automatic logic [WORD_SIZE-1:0] word_inc(input logic [WORD_SIZE-1:0] w);
        return (w == WORD_MAX) ? w : w + ONE_W;
    endfunction

    // Table storage: valid/counter are control state, tag/target are data
    logic                 valid_mem  [ENTRIES];
    logic [CNT_BITS-1:0]  cnt_mem    [ENTRIES];
    logic [TAG_W-1:0]     tag_mem    [ENTRIES];
    logic [WORD_SIZE-1:0] target_mem [ENTRIES];

    logic [IDX_BITS-1:0]  if_idx;
    logic [TAG_W-1:0]     if_tag;
    logic [IDX_BITS-1:0]  id_idx;
    logic [TAG_W-1:0]     id_tag;
    logic [WORD_SIZE-1:0] if_pc_1;
    logic                 if_hit;
    logic                 id_hit;
    logic                 q;
    logic                 any_class;

    logic                 wr_en;
    logic                 wr_valid;
    logic [CNT_BITS-1:0]  wr_cnt;
    logic [WORD_SIZE-1:0] wr_target;

    assign if_idx    = if_pc[IDX_BITS-1:0];
    assign if_tag    = if_pc[WORD_SIZE-1:IDX_BITS];
    assign id_idx    = id_pc[IDX_BITS-1:0];
    assign id_tag    = id_pc[WORD_SIZE-1:IDX_BITS];
    assign if_pc_1   = if_pc + ONE_W;
    assign q         = id_valid && !stall;
    assign any_class = is_jtype || is_branch || is_jr;

    assign if_hit = valid_mem[if_idx] && (tag_mem[if_idx] == if_tag);
    assign id_hit = valid_mem[id_idx] && (tag_mem[id_idx] == id_tag);

    // Predict: taken target only on a hit with the counter MSB set
    always_comb begin
        pred_pc = if_pc_1;
        if (if_hit && cnt_mem[if_idx][CNT_BITS-1]) begin
            pred_pc = target_mem[if_idx];
        end
    end

    // Resolve: first mismatch in priority order selects the flush and redirect
    always_comb begin
        flush_code = FL_NICE;
        correct_pc = if_pc_1;
        if (q) begin
            correct_pc = pred_pc;
            if (is_jtype && if_pc != jmp_target) begin
                flush_code = FL_JUMP;
                correct_pc = jmp_target;
            end else if (is_branch && br_cond && if_pc != br_target) begin
                flush_code = FL_BR_TK;
                correct_pc = br_target;
            end else if (is_branch && !br_cond && if_pc != id_pc_1) begin
                flush_code = FL_BR_NT;
                correct_pc = id_pc_1;
            end else if (is_jr && if_pc != jr_target) begin
                flush_code = FL_JR;
                correct_pc = jr_target;
            end else if (!any_class && if_pc != id_pc_1) begin
                flush_code = FL_FALSE;
                correct_pc = id_pc_1;
            end
        end
    end

    // Train: decide which entry write, if any, the resolved instruction causes
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = 1'b1;
        wr_cnt    = cnt_mem[id_idx];
        wr_target = target_mem[id_idx];
        if (q) begin
            if (is_jtype || is_jr) begin
                wr_en     = 1'b1;
                wr_cnt    = CNT_MAX;
                wr_target = is_jtype ? jmp_target : jr_target;
            end else if (is_branch && id_hit) begin
                wr_en     = 1'b1;
                wr_cnt    = br_cond ? cnt_inc(cnt_mem[id_idx]) : cnt_dec(cnt_mem[id_idx]);
                wr_target = br_target;
            end else if (is_branch && br_cond) begin
                wr_en     = 1'b1;
                wr_cnt    = CNT_WEAK;
                wr_target = br_target;
            end else if (flush_code == FL_FALSE) begin
                wr_en     = 1'b1;
                wr_valid  = 1'b0;
            end
        end
    end

    // Control state: valid bits, counters and perf counters, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i] <= 1'b0;
                cnt_mem[i]   <= '0;
            end
            ctrl_count    <= '0;
            mispred_count <= '0;
        end else begin
            if (wr_en) begin
                valid_mem[id_idx] <= wr_valid;
                cnt_mem[id_idx]   <= wr_cnt;
            end
            if (q && any_class) begin
                ctrl_count <= word_inc(ctrl_count);
            end
            if (flush_code != FL_NICE) begin
                mispred_count <= word_inc(mispred_count);
            end
        end
    end

    // Data state: tag and target are only meaningful behind a valid bit
    always_ff @(posedge clk) begin
        if (wr_en && wr_valid) begin
            tag_mem[id_idx]    <= id_tag;
            target_mem[id_idx] <= wr_target;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios followed by random
// traffic, all checked against an array-based reference model of the table.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] if_pc, pred_pc, id_pc, id_pc_1;
    logic        id_valid, stall, is_jtype, is_branch, is_jr, br_cond;
    logic [15:0] jmp_target, br_target, jr_target;
    logic [2:0]  flush_code;
    logic [15:0] correct_pc, ctrl_count, mispred_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_valid [16];
    logic [11:0] m_tag   [16];
    logic [15:0] m_tgt   [16];
    int          m_cnt   [16];
    int          m_ctrl;
    int          m_misp;
    int          exp_flush;
    logic [15:0] exp_correct;

    always #5 clk = ~clk;

    branch_target_predictor dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .pred_pc(pred_pc),
        .id_valid(id_valid), .stall(stall), .id_pc(id_pc), .id_pc_1(id_pc_1),
        .is_jtype(is_jtype), .is_branch(is_branch), .is_jr(is_jr), .br_cond(br_cond),
        .jmp_target(jmp_target), .br_target(br_target), .jr_target(jr_target),
        .flush_code(flush_code), .correct_pc(correct_pc),
        .ctrl_count(ctrl_count), .mispred_count(mispred_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_cnt[i]   = 0;
        end
        m_ctrl = 0;
        m_misp = 0;
    endtask

    function automatic logic [15:0] model_pred(input logic [15:0] pc);
        int i = int'(pc[3:0]);
        if (m_valid[i] && m_tag[i] == pc[15:4] && m_cnt[i] >= 2) return m_tgt[i];
        return pc + 16'd1;
    endfunction

    task automatic model_resolve();
        if (!(id_valid && !stall)) begin
            exp_flush = 0; exp_correct = if_pc + 16'd1;
        end else if (is_jtype && if_pc != jmp_target) begin
            exp_flush = 1; exp_correct = jmp_target;
        end else if (is_branch && br_cond && if_pc != br_target) begin
            exp_flush = 2; exp_correct = br_target;
        end else if (is_branch && !br_cond && if_pc != id_pc_1) begin
            exp_flush = 3; exp_correct = id_pc_1;
        end else if (is_jr && if_pc != jr_target) begin
            exp_flush = 4; exp_correct = jr_target;
        end else if (!is_jtype && !is_branch && !is_jr && if_pc != id_pc_1) begin
            exp_flush = 5; exp_correct = id_pc_1;
        end else begin
            exp_flush = 0; exp_correct = model_pred(if_pc);
        end
    endtask

    task automatic model_train();
        int  i;
        bit  hit;
        if (reset || !(id_valid && !stall)) return;
        i   = int'(id_pc[3:0]);
        hit = m_valid[i] && m_tag[i] == id_pc[15:4];
        if (is_jtype || is_jr) begin
            m_valid[i] = 1; m_tag[i] = id_pc[15:4]; m_cnt[i] = 3;
            m_tgt[i] = is_jtype ? jmp_target : jr_target;
        end else if (is_branch && hit) begin
            m_cnt[i] = br_cond ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                               : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            m_tgt[i] = br_target;
        end else if (is_branch && br_cond) begin
            m_valid[i] = 1; m_tag[i] = id_pc[15:4]; m_cnt[i] = 2; m_tgt[i] = br_target;
        end else if (exp_flush == 5) begin
            m_valid[i] = 0;
        end
        if ((is_jtype || is_branch || is_jr) && m_ctrl < 65535) m_ctrl++;
        if (exp_flush != 0 && m_misp < 65535) m_misp++;
    endtask

    // Drive one ID/IF cycle and check every combinational output and counter
    task automatic apply(input logic [15:0] ipc, input logic v, input logic st,
                         input logic [15:0] dpc, input logic [2:0] cls, input logic cond,
                         input logic [15:0] jt, input logic [15:0] bt, input logic [15:0] rt);
        if_pc = ipc; id_valid = v; stall = st; id_pc = dpc; id_pc_1 = dpc + 16'd1;
        is_jtype = cls[0]; is_branch = cls[1]; is_jr = cls[2]; br_cond = cond;
        jmp_target = jt; br_target = bt; jr_target = rt;
        #1;
        model_resolve();
        chk("pred_pc", pred_pc, model_pred(if_pc));
        chk("flush_code", 16'(flush_code), 16'(exp_flush));
        chk("correct_pc", correct_pc, exp_correct);
        chk("ctrl_count", ctrl_count, 16'(m_ctrl));
        chk("mispred_count", mispred_count, 16'(m_misp));
    endtask

    task automatic edge_step();
        model_train();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] ipc);
        apply(ipc, 1'b0, 1'b0, 16'h0, 3'b000, 1'b0, 16'h0, 16'h0, 16'h0);
    endtask

    localparam logic [2:0] C_J = 3'b001, C_B = 3'b010, C_R = 3'b100, C_N = 3'b000;

    initial begin
        logic [15:0] dpc, ipc, base;
        logic [2:0]  cls;
        int          sel;

        model_reset();
        reset = 1'b1;
        idle(16'h0010);
        chk("rst_pred", pred_pc, 16'h0011);
        chk("rst_corr", correct_pc, 16'h0011);
        chk("rst_ctrl", ctrl_count, 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(16'h0010);
        chk("post_rst_pred", pred_pc, 16'h0011);
        edge_step();

        // Jump training
        apply(16'h0021, 1, 0, 16'h0020, C_J, 0, 16'h0040, 16'h0, 16'h0);
        chk("j_flush", 16'(flush_code), 16'd1);
        chk("j_corr", correct_pc, 16'h0040);
        edge_step();
        idle(16'h0020);
        chk("j_pred", pred_pc, 16'h0040);
        chk("j_misp", mispred_count, 16'd1);
        edge_step();

        // Branch allocate then retrain
        apply(16'h0034, 1, 0, 16'h0033, C_B, 1, 16'h0, 16'h0050, 16'h0);
        chk("b_alloc_flush", 16'(flush_code), 16'd2);
        edge_step();
        idle(16'h0033);
        chk("b_pred_tk", pred_pc, 16'h0050);
        edge_step();
        apply(16'h0050, 1, 0, 16'h0033, C_B, 0, 16'h0, 16'h0050, 16'h0);
        chk("b_nt_flush", 16'(flush_code), 16'd3);
        chk("b_nt_corr", correct_pc, 16'h0034);
        edge_step();
        idle(16'h0033);
        chk("b_pred_nt", pred_pc, 16'h0034);
        edge_step();

        // Saturation: four taken, one not-taken still predicts taken
        for (int k = 0; k < 4; k++) begin
            apply(16'h0050, 1, 0, 16'h0033, C_B, 1, 16'h0, 16'h0050, 16'h0);
            edge_step();
        end
        apply(16'h0050, 1, 0, 16'h0033, C_B, 0, 16'h0, 16'h0050, 16'h0);
        chk("sat_flush", 16'(flush_code), 16'd3);
        edge_step();
        idle(16'h0033);
        chk("sat_pred", pred_pc, 16'h0050);
        edge_step();

        // Register-jump retarget
        apply(16'h0045, 1, 0, 16'h0044, C_R, 0, 16'h0, 16'h0, 16'h0100);
        chk("jr_flush1", 16'(flush_code), 16'd4);
        edge_step();
        apply(16'h0100, 1, 0, 16'h0044, C_R, 0, 16'h0, 16'h0, 16'h0200);
        chk("jr_flush2", 16'(flush_code), 16'd4);
        chk("jr_corr2", correct_pc, 16'h0200);
        edge_step();
        idle(16'h0044);
        chk("jr_pred", pred_pc, 16'h0200);
        edge_step();

        // Stall blocks flush, training and counting
        apply(16'h0061, 1, 1, 16'h0060, C_J, 0, 16'h0070, 16'h0, 16'h0);
        chk("stall_flush", 16'(flush_code), 16'd0);
        edge_step();
        idle(16'h0060);
        chk("stall_pred", pred_pc, 16'h0061);
        edge_step();

        // Random traffic with a mid-run reset pulse
        for (int n = 0; n < 400; n++) begin
            base = ($urandom_range(0, 3) == 0) ? 16'h0100 : 16'h0000;
            dpc  = base | 16'($urandom_range(0, 31));
            sel  = $urandom_range(0, 9);
            cls  = (sel < 3) ? C_B : (sel < 5) ? C_J : (sel < 7) ? C_R : C_N;
            br_cond = 1'($urandom);
            jmp_target = 16'($urandom_range(0, 63));
            br_target  = 16'($urandom_range(0, 63));
            jr_target  = 16'($urandom_range(0, 63));
            sel = $urandom_range(0, 5);
            ipc = (sel == 0) ? dpc + 16'd1 : (sel == 1) ? jmp_target :
                  (sel == 2) ? br_target : (sel == 3) ? jr_target :
                  (sel == 4) ? model_pred(dpc) : 16'($urandom_range(0, 63));
            apply(ipc, ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0), dpc, cls,
                  br_cond, jmp_target, br_target, jr_target);
            if (n == 250) begin
                reset = 1'b1;
                #1;
                model_reset();
                chk("midrst_pred", pred_pc, if_pc + 16'd1);
                chk("midrst_ctrl", ctrl_count, 16'd0);
                chk("midrst_misp", mispred_count, 16'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                idle(dpc);
                chk("midrst_after", pred_pc, dpc + 16'd1);
            end
            edge_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
